// File: rtl/decode_modrm_fetch.sv
// Collects ModR/M, optional SIB and 0/1/2/4 displacement bytes into one registered record.
// Define DECODE_MODRM_FETCH_ADDR16_EN to support 16-bit addressing; otherwise 32-bit is forced.
module decode_modrm_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        address_size_32,
  input  logic        flush,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  modrm,
  output logic [7:0]  sib,
  output logic        sib_is_present,
  output logic [31:0] displacement,
  output logic [1:0]  disp_size,
  output logic [2:0]  bytes_consumed
);

  typedef enum logic [2:0] {StIdle, StModrm, StSib, StDisp, StHold} state_e;

  state_e      state;
  logic [2:0]  remaining;
  logic [1:0]  byte_idx;
  logic        addr32;
  logic        transfer;
  logic [2:0]  modrm_len;
  logic [2:0]  sib_len;

`ifdef DECODE_MODRM_FETCH_ADDR16_EN
  logic addr32_q;
  assign addr32 = addr32_q;
`else
  logic unused_address_size_32;
  assign unused_address_size_32 = address_size_32;
  assign addr32 = 1'b1;
`endif

  // Displacement length implied by a ModR/M byte when no SIB follows.
  function automatic logic [2:0] calc_modrm_len(input logic [7:0] m, input logic a32);
    logic [2:0] len;
    len = 3'd0;
    if (a32) begin
      if (m[7:6] == 2'b00 && m[2:0] == 3'b101) len = 3'd4;
      else if (m[7:6] == 2'b01)                len = 3'd1;
      else if (m[7:6] == 2'b10)                len = 3'd4;
    end
`ifdef DECODE_MODRM_FETCH_ADDR16_EN
    else begin
      if (m[7:6] == 2'b00 && m[2:0] == 3'b110) len = 3'd2;
      else if (m[7:6] == 2'b01)                len = 3'd1;
      else if (m[7:6] == 2'b10)                len = 3'd2;
    end
`endif
    return len;
  endfunction

  function automatic logic [2:0] calc_sib_len(input logic [1:0] mod, input logic [2:0] base);
    logic [2:0] len;
    len = 3'd0;
    if (mod == 2'b00 && base == 3'b101) len = 3'd4;
    else if (mod == 2'b01)              len = 3'd1;
    else if (mod == 2'b10)              len = 3'd4;
    return len;
  endfunction

  function automatic logic [1:0] size_code(input logic [2:0] len);
    logic [1:0] code;
    code = 2'b00;
    if (len == 3'd1)      code = 2'b01;
    else if (len == 3'd2) code = 2'b10;
    else if (len == 3'd4) code = 2'b11;
    return code;
  endfunction

  assign byte_ready = (state == StModrm || state == StSib || state == StDisp) && !flush;
  assign transfer   = byte_valid && byte_ready;
  assign modrm_len  = calc_modrm_len(byte_data, addr32);
  assign sib_len    = calc_sib_len(modrm[7:6], byte_data[2:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      busy           <= 1'b0;
      out_valid      <= 1'b0;
      modrm          <= 8'h00;
      sib            <= 8'h00;
      sib_is_present <= 1'b0;
      displacement   <= 32'h0;
      disp_size      <= 2'b00;
      bytes_consumed <= 3'd0;
      remaining      <= 3'd0;
      byte_idx       <= 2'd0;
`ifdef DECODE_MODRM_FETCH_ADDR16_EN
      addr32_q       <= 1'b0;
`endif
    end else if (flush) begin
      state          <= StIdle;
      busy           <= 1'b0;
      out_valid      <= 1'b0;
      modrm          <= 8'h00;
      sib            <= 8'h00;
      sib_is_present <= 1'b0;
      displacement   <= 32'h0;
      disp_size      <= 2'b00;
      bytes_consumed <= 3'd0;
      remaining      <= 3'd0;
      byte_idx       <= 2'd0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            state          <= StModrm;
            busy           <= 1'b1;
            modrm          <= 8'h00;
            sib            <= 8'h00;
            sib_is_present <= 1'b0;
            displacement   <= 32'h0;
            disp_size      <= 2'b00;
            bytes_consumed <= 3'd0;
            remaining      <= 3'd0;
            byte_idx       <= 2'd0;
`ifdef DECODE_MODRM_FETCH_ADDR16_EN
            addr32_q       <= address_size_32;
`endif
          end
        end
        StModrm: begin
          if (transfer) begin
            modrm          <= byte_data;
            bytes_consumed <= bytes_consumed + 3'd1;
            if (addr32 && byte_data[7:6] != 2'b11 && byte_data[2:0] == 3'b100) begin
              state <= StSib;
            end else begin
              disp_size <= size_code(modrm_len);
              remaining <= modrm_len;
              state     <= (modrm_len != 3'd0) ? StDisp : StHold;
              out_valid <= (modrm_len == 3'd0);
            end
          end
        end
        StSib: begin
          if (transfer) begin
            sib            <= byte_data;
            sib_is_present <= 1'b1;
            bytes_consumed <= bytes_consumed + 3'd1;
            disp_size      <= size_code(sib_len);
            remaining      <= sib_len;
            state          <= (sib_len != 3'd0) ? StDisp : StHold;
            out_valid      <= (sib_len == 3'd0);
          end
        end
        StDisp: begin
          if (transfer) begin
            bytes_consumed <= bytes_consumed + 3'd1;
            if (remaining == 3'd1) begin
              // Short displacements end on their top byte, so sign-extend from it.
              case (disp_size)
                2'b01:   displacement <= {{24{byte_data[7]}}, byte_data};
                2'b10:   displacement <= {{16{byte_data[7]}}, byte_data, displacement[7:0]};
                default: displacement[{byte_idx, 3'b000} +: 8] <= byte_data;
              endcase
              state     <= StHold;
              out_valid <= 1'b1;
            end else begin
              displacement[{byte_idx, 3'b000} +: 8] <= byte_data;
              remaining <= remaining - 3'd1;
              byte_idx  <= byte_idx + 2'd1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state     <= StIdle;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_modrm_fetch.sv
// Directed bench for decode_modrm_fetch: a record-level model checked every valid cycle,
// plus literal expectations taken from worked examples.
module tb_decode_modrm_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        address_size_32 = 1'b0;
  logic        flush = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  modrm;
  logic [7:0]  sib;
  logic        sib_is_present;
  logic [31:0] displacement;
  logic [1:0]  disp_size;
  logic [2:0]  bytes_consumed;

  decode_modrm_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .address_size_32(address_size_32),
    .flush          (flush),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .modrm          (modrm),
    .sib            (sib),
    .sib_is_present (sib_is_present),
    .displacement   (displacement),
    .disp_size      (disp_size),
    .bytes_consumed (bytes_consumed)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  modrm;
    logic [7:0]  sib;
    logic        sibp;
    logic [31:0] disp;
    logic [1:0]  dsz;
    logic [2:0]  cnt;
  } rec_t;

  int   tests = 0;
  int   fails = 0;
  logic armed = 1'b0;
  rec_t exp_rec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Whole-instruction view: decide layout from the byte string, then assemble the record.
  function automatic rec_t model(input logic [7:0] b[6], input logic a32_in);
    rec_t r;
    logic a32;
    int len, idx;
    logic [31:0] raw;
    logic [1:0] md;
    logic [2:0] rm;
    a32 = a32_in;
`ifndef DECODE_MODRM_FETCH_ADDR16_EN
    a32 = 1'b1;
`endif
    r = '0;
    r.modrm = b[0];
    md = b[0][7:6];
    rm = b[0][2:0];
    idx = 1;
    len = 0;
    if (a32 && md != 2'd3 && rm == 3'd4) begin
      r.sib = b[1];
      r.sibp = 1'b1;
      idx = 2;
      if (md == 2'd1) len = 1;
      else if (md == 2'd2) len = 4;
      else if (b[1][2:0] == 3'd5) len = 4;
    end else if (a32) begin
      if (md == 2'd0 && rm == 3'd5) len = 4;
      else if (md == 2'd1) len = 1;
      else if (md == 2'd2) len = 4;
    end else begin
      if (md == 2'd0 && rm == 3'd6) len = 2;
      else if (md == 2'd1) len = 1;
      else if (md == 2'd2) len = 2;
    end
    raw = 32'h0;
    for (int k = 0; k < len; k++) raw = raw | (32'(b[idx + k]) << (8 * k));
    if (len == 1)      r.disp = {{24{raw[7]}}, raw[7:0]};
    else if (len == 2) r.disp = {{16{raw[15]}}, raw[15:0]};
    else               r.disp = raw;
    r.dsz = (len == 0) ? 2'd0 : (len == 1) ? 2'd1 : (len == 2) ? 2'd2 : 2'd3;
    r.cnt = 3'(idx + len);
    return r;
  endfunction

  always @(negedge clock) begin
    if (armed && out_valid) begin
      check("rec.modrm", 32'(modrm), 32'(exp_rec.modrm));
      check("rec.sib", 32'(sib), 32'(exp_rec.sib));
      check("rec.sib_is_present", 32'(sib_is_present), 32'(exp_rec.sibp));
      check("rec.displacement", displacement, exp_rec.disp);
      check("rec.disp_size", 32'(disp_size), 32'(exp_rec.dsz));
      check("rec.bytes_consumed", 32'(bytes_consumed), 32'(exp_rec.cnt));
    end
  end

  task automatic run_txn(input logic [7:0] b[6], input logic a32, input int stall_at,
                         input int stall_len, input int hold_len);
    int n;
    exp_rec = model(b, a32);
    n = int'(exp_rec.cnt);
    armed = 1'b1;
    @(posedge clock); #1;
    start = 1'b1;
    address_size_32 = a32;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        byte_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clock);
          check("stall.out_valid", 32'(out_valid), 32'd0);
          check("stall.busy", 32'(busy), 32'd1);
          @(posedge clock); #1;
        end
      end
      byte_valid = 1'b1;
      byte_data = b[i];
      @(negedge clock);
      check("byte_ready", 32'(byte_ready), 32'd1);
      @(posedge clock); #1;
    end
    byte_valid = 1'b0;
    @(negedge clock);
    check("out_valid.rise", 32'(out_valid), 32'd1);
    @(posedge clock); #1;
    for (int h = 0; h < hold_len; h++) begin
      start = 1'b1;
      @(negedge clock);
      check("hold.out_valid", 32'(out_valid), 32'd1);
      check("hold.byte_ready", 32'(byte_ready), 32'd0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("exit.out_valid", 32'(out_valid), 32'd0);
    check("exit.busy", 32'(busy), 32'd0);
    armed = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".modrm"}, 32'(modrm), 32'd0);
    check({tag, ".sib"}, 32'(sib), 32'd0);
    check({tag, ".sib_is_present"}, 32'(sib_is_present), 32'd0);
    check({tag, ".displacement"}, displacement, 32'd0);
    check({tag, ".disp_size"}, 32'(disp_size), 32'd0);
    check({tag, ".bytes_consumed"}, 32'(bytes_consumed), 32'd0);
  endtask

  logic [7:0] v[6];

  initial begin
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    v = '{8'h44, 8'hF3, 8'h20, 8'h00, 8'h00, 8'h00};
    run_txn(v, 1'b1, -1, 0, 0);
    check("t1.sib", 32'(sib), 32'hF3);
    check("t1.displacement", displacement, 32'h00000020);
    check("t1.disp_size", 32'(disp_size), 32'd1);
    check("t1.bytes_consumed", 32'(bytes_consumed), 32'd3);

    v = '{8'h40, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(v, 1'b0, -1, 0, 0);
    check("t2.sib_is_present", 32'(sib_is_present), 32'd0);
    check("t2.displacement", displacement, 32'h00000006);
    check("t2.bytes_consumed", 32'(bytes_consumed), 32'd2);

    v = '{8'h06, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00};
    run_txn(v, 1'b0, -1, 0, 0);
`ifdef DECODE_MODRM_FETCH_ADDR16_EN
    check("t3.displacement", displacement, 32'h00001234);
    check("t3.disp_size", 32'(disp_size), 32'd2);
    check("t3.bytes_consumed", 32'(bytes_consumed), 32'd3);
`else
    check("t3.displacement", displacement, 32'h00000000);
    check("t3.disp_size", 32'(disp_size), 32'd0);
    check("t3.bytes_consumed", 32'(bytes_consumed), 32'd1);
`endif

    v = '{8'h04, 8'h25, 8'h78, 8'h56, 8'h34, 8'h12};
    run_txn(v, 1'b1, -1, 0, 0);
    check("t4.displacement", displacement, 32'h12345678);
    check("t4.disp_size", 32'(disp_size), 32'd3);
    check("t4.bytes_consumed", 32'(bytes_consumed), 32'd6);

    v = '{8'h84, 8'h24, 8'h80, 8'hFF, 8'hFF, 8'hFF};
    run_txn(v, 1'b1, -1, 0, 0);
    check("t5.displacement", displacement, 32'hFFFFFF80);
    check("t5.bytes_consumed", 32'(bytes_consumed), 32'd6);

    v = '{8'h45, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(v, 1'b1, 1, 3, 0);
    check("t6.displacement", displacement, 32'hFFFFFFF0);
    check("t6.disp_size", 32'(disp_size), 32'd1);

    v = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(v, 1'b1, -1, 0, 5);
    check("t7.disp_size", 32'(disp_size), 32'd0);
    check("t7.bytes_consumed", 32'(bytes_consumed), 32'd1);

    // Model-only cases: 16-bit mod 10 and 32-bit disp32-only form.
    v = '{8'h80, 8'h00, 8'h80, 8'h7F, 8'h00, 8'h00};
    run_txn(v, 1'b0, -1, 0, 1);
    v = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    run_txn(v, 1'b1, 2, 2, 0);

    // Flush after two of four displacement bytes.
    @(posedge clock); #1;
    start = 1'b1;
    address_size_32 = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    v = '{8'h04, 8'h25, 8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_data = v[i];
      @(posedge clock); #1;
    end
    byte_data = v[4];
    flush = 1'b1;
    @(negedge clock);
    check("flush.byte_ready", 32'(byte_ready), 32'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    byte_valid = 1'b0;
    @(negedge clock);
    check_all_zero("flush");
    @(posedge clock); #1;
    @(negedge clock);
    check("flush.later_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while waiting for the SIB byte.
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'h04;
    @(posedge clock); #1;
    byte_data = 8'h25;
    #1;
    check("sib.byte_ready", 32'(byte_ready), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    #1;
    reset = 1'b0;
    byte_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("post_reset.busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_modrm_fetch.md
# decode_modrm_fetch

Sequential byte-collection stage upstream of `decode_mod_rm`. After the opcode decoder signals that the current opcode carries a ModR/M byte, this block consumes the ModR/M byte, the optional SIB byte and a displacement of 0, 1, 2 or 4 bytes from the prefetch byte stream. It presents them as one registered record to `decode_mod_rm` and the effective-address stage. Field lengths are resolved on the fly from `mod`, `rm` and the SIB base field under the current address size.

## Interface
- Parameters: none.
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to fetch ModR/M fields; honoured only in IDLE
- `address_size_32`  in  1  1 = 32-bit addressing, 0 = 16-bit; sampled when `start` is accepted
- `flush`  in  1  synchronous abort (branch, fault); highest priority after reset
- `byte_valid`  in  1  prefetch queue has a byte
- `byte_data`  in  8  byte from the prefetch queue
- `byte_ready`  out  1  block accepts `byte_data` this cycle
- `busy`  out  1  block is not in IDLE
- `out_valid`  out  1  record valid; held until `out_ready`
- `out_ready`  in  1  consumer accepts the record
- `modrm`  out  8  captured ModR/M byte
- `sib`  out  8  captured SIB byte; 0 when absent
- `sib_is_present`  out  1  SIB byte was consumed
- `displacement`  out  32  displacement, sign-extended to 32 bits
- `disp_size`  out  2  00 = none, 01 = 8-bit, 10 = 16-bit, 11 = 32-bit
- `bytes_consumed`  out  3  total bytes consumed, 1 to 6

## Operation
- States: IDLE, MODRM, SIB, DISP, HOLD.
- Byte transfer occurs on a cycle with `byte_valid && byte_ready`.
- `byte_ready` = 1 only in MODRM, SIB and DISP.
- IDLE, `start` = 1: latch `address_size_32`, clear all record fields, go to MODRM.
- MODRM, on transfer: capture `modrm`, then:
  - 32-bit mode, mod != 11, rm = 100: go to SIB.
  - Displacement length > 0: go to DISP.
  - Otherwise: go to HOLD.
- 16-bit displacement length:
  - mod 00, rm 110: 2
  - mod 01: 1
  - mod 10: 2
  - all other cases: 0
- 32-bit displacement length, no SIB:
  - mod 00, rm 101: 4
  - mod 01: 1
  - mod 10: 4
  - all other cases: 0
- SIB, on transfer: capture `sib`, set `sib_is_present`, then:
  - mod 00 with SIB base = 101: 4
  - mod 01: 1
  - mod 10: 4
  - mod 00 with any other base: 0
  - Go to DISP if the length is > 0, else go to HOLD.
- DISP:
  - Bytes are little-endian; byte k fills `displacement[8k+7:8k]`.
  - A down-counter tracks the remaining bytes.
  - On the last byte, sign-extend from bit 7 (length 1) or bit 15 (length 2), then go to HOLD.
- HOLD: `out_valid` = 1; the record is stable. On `out_ready`, go to IDLE.
- `bytes_consumed` increments on every transfer.
- `start` outside IDLE is ignored. A `start` in the same cycle as a HOLD-to-IDLE exit is also ignored.
- `flush` in any state: next state IDLE, `out_valid` = 0, record cleared. Any byte presented that cycle is not consumed (`byte_ready` forced to 0).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.

## Timing
- Reset value of every output is 0, including `byte_ready`, `busy` and `out_valid`.
- All outputs are registered except `byte_ready`, which is decoded from state and `flush`.
- Cycle 0: `start` is accepted. Cycle 1: first byte can transfer.
- With `byte_valid` held high, N bytes transfer in cycles 1 to N and `out_valid` rises in cycle N+1.
- There are no bubbles between consecutive bytes.
- `byte_valid` low stalls the FSM indefinitely with no state change.
- `out_ready` low holds HOLD indefinitely.
- IDLE is re-entered the cycle after the HOLD handshake. The earliest next `start` is accepted in that IDLE cycle.

## Configuration
- Macro: `DECODE_MODRM_FETCH_ADDR16_EN`.
- Defined: 16-bit addressing rules are supported as above.
- Undefined:
  - `address_size_32` is ignored and treated as 1.
  - The 16-bit length decode is not compiled.
  - `disp_size` is never 10.

## Test plan
- 32-bit, bytes 44 F3 20 → `modrm` 44, `sib` F3, `sib_is_present` 1, `displacement` 00000020, `disp_size` 01, `bytes_consumed` 3, `out_valid` at cycle 4.
- 16-bit, bytes 40 06 → `modrm` 40, `sib_is_present` 0, `displacement` 00000006, `disp_size` 01, `bytes_consumed` 2. Then 16-bit 06 34 12 → `displacement` 00001234, `disp_size` 10, `bytes_consumed` 3.
- 32-bit, 04 25 78 56 34 12 (SIB base 101, mod 00) → `displacement` 12345678, `disp_size` 11, `bytes_consumed` 6. Then 84 24 80 FF FF FF → `displacement` FFFFFF80, `bytes_consumed` 6.
- 32-bit, 45 F0, with `byte_valid` low for 3 cycles between bytes → `displacement` FFFFFFF0, `disp_size` 01. Then C3 → `disp_size` 00, `bytes_consumed` 1, no DISP state.
- `out_ready` held low 5 cycles in HOLD → record stable, `start` ignored. Release → IDLE next cycle.
- `flush` during DISP after 2 of 4 bytes → `byte_ready` 0 that cycle, IDLE next cycle, `out_valid` stays 0. Async `reset` asserted mid-SIB → all outputs 0 immediately.
